wall_datapath: RTL

//  Wall datapath, directly downstream of the wall control FSM. Decodes its 4-bit state code, owns wall X position,

---
 rtl/wall_datapath.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/wall_datapath.sv
// Wall datapath: decodes the wall FSM state code, owns the wall X position and sweeps erase/draw
// rectangles to the VGA adapter one pixel per clock. Optional macro WALL_WRAP_EN: wall re-enters from the right.
module wall_datapath #(
  parameter logic [7:0]  X_START = 8'd156,
  parameter logic [6:0]  Y_TOP   = 7'd40,
  parameter int unsigned WALL_W  = 4,
  parameter int unsigned WALL_H  = 40,
  parameter logic [7:0]  SPEED   = 8'd1,
  parameter logic [2:0]  COLOUR  = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] current_in,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] wall_x,
  output logic       touched,
  output logic       busy
);

  localparam int unsigned CXW = (WALL_W > 1) ? $clog2(WALL_W) : 1;
  localparam int unsigned CYW = (WALL_H > 1) ? $clog2(WALL_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(WALL_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(WALL_H - 1);
  localparam logic [8:0]     X_MAX   = 9'd159;

  localparam logic [3:0] ST_READY  = 4'h5;
  localparam logic [3:0] ST_MOVE   = 4'h6;
  localparam logic [3:0] ST_STOP   = 4'h7;
  localparam logic [3:0] ST_DRAW   = 4'h8;
  localparam logic [3:0] ST_DEL    = 4'h9;
  localparam logic [3:0] ST_UPDATE = 4'hA;

  typedef enum logic [1:0] {SW_IDLE, SW_ERASE, SW_DRAW} sweep_e;

  sweep_e         sweep_q, sweep_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [7:0]     base_q, base_d;
  logic [7:0]     wall_x_q, wall_x_d;
  logic           moving_q, moving_d;
  logic           restart_q, restart_d;
  logic           frame_open_q, frame_open_d;
  logic           draw_pending_q, draw_pending_d;
  logic [7:0]     vga_x_q, vga_x_d;
  logic [6:0]     vga_y_q, vga_y_d;
  logic [2:0]     vga_colour_q, vga_colour_d;
  logic           vga_plot_q, vga_plot_d;
  logic           touched_q, touched_d;
  logic           busy_q, busy_d;
  logic [8:0]     pix_x9;
  logic [8:0]     px9, wx9;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_q        <= SW_IDLE;
      cx_q           <= '0;
      cy_q           <= '0;
      base_q         <= '0;
      wall_x_q       <= X_START;
      moving_q       <= 1'b0;
      restart_q      <= 1'b0;
      frame_open_q   <= 1'b0;
      draw_pending_q <= 1'b0;
      vga_x_q        <= '0;
      vga_y_q        <= '0;
      vga_colour_q   <= '0;
      vga_plot_q     <= 1'b0;
      touched_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sweep_q        <= sweep_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      base_q         <= base_d;
      wall_x_q       <= wall_x_d;
      moving_q       <= moving_d;
      restart_q      <= restart_d;
      frame_open_q   <= frame_open_d;
      draw_pending_q <= draw_pending_d;
      vga_x_q        <= vga_x_d;
      vga_y_q        <= vga_y_d;
      vga_colour_q   <= vga_colour_d;
      vga_plot_q     <= vga_plot_d;
      touched_q      <= touched_d;
      busy_q         <= busy_d;
    end
  end

  // State-code decode, wall motion and sweep sequencing; pixel outputs follow the next sweep position.
  always_comb begin
    sweep_d        = sweep_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    base_d         = base_q;
    wall_x_d       = wall_x_q;
    moving_d       = moving_q;
    restart_d      = restart_q;
    frame_open_d   = frame_open_q;
    draw_pending_d = draw_pending_q;

    case (current_in)
      ST_READY: begin
        moving_d  = 1'b0;
        restart_d = 1'b1;
      end
      ST_MOVE: moving_d = 1'b1;
      ST_STOP: moving_d = 1'b0;
      ST_DEL: begin
        if (sweep_q == SW_IDLE) frame_open_d = 1'b1;
      end
      ST_UPDATE: begin
        if (frame_open_q) begin
          if (restart_q) begin
            wall_x_d  = X_START;
            restart_d = 1'b0;
          end else if (moving_q) begin
            if (wall_x_q < SPEED) begin
`ifdef WALL_WRAP_EN
              wall_x_d = X_START;
`else
              wall_x_d = 8'd0;
`endif
            end else begin
              wall_x_d = wall_x_q - SPEED;
            end
          end
        end
      end
      ST_DRAW: begin
        if (frame_open_q) begin
          draw_pending_d = 1'b1;
          frame_open_d   = 1'b0;
        end
      end
      default: ;
    endcase

    case (sweep_q)
      SW_IDLE: begin
        if (current_in == ST_DEL) begin
          sweep_d = SW_ERASE;
          base_d  = wall_x_q;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      SW_ERASE, SW_DRAW: begin
        if (cx_q == CX_LAST) begin
          cx_d = '0;
          if (cy_q == CY_LAST) begin
            cy_d = '0;
            // Draw phase follows erase back-to-back when a DRAW was seen during this frame
            if (sweep_q == SW_ERASE && draw_pending_q) begin
              sweep_d        = SW_DRAW;
              base_d         = wall_x_q;
              draw_pending_d = 1'b0;
            end else begin
              sweep_d = SW_IDLE;
            end
          end else begin
            cy_d = cy_q + CYW'(1);
          end
        end else begin
          cx_d = cx_q + CXW'(1);
        end
      end
      default: sweep_d = SW_IDLE;
    endcase

    pix_x9       = {1'b0, base_d} + 9'(cx_d);
    busy_d       = (sweep_d != SW_IDLE);
    vga_plot_d   = busy_d && (pix_x9 <= X_MAX);
    vga_x_d      = busy_d ? pix_x9[7:0] : 8'd0;
    vga_y_d      = busy_d ? (Y_TOP + 7'(cy_d)) : 7'd0;
    vga_colour_d = (sweep_d == SW_DRAW) ? COLOUR : 3'b000;

    px9       = {1'b0, player_x};
    wx9       = {1'b0, wall_x_q};
    touched_d = (px9 >= wx9) && (px9 <= wx9 + 9'(WALL_W - 1)) &&
                (player_y >= Y_TOP) && (player_y <= Y_TOP + 7'(WALL_H - 1));
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign wall_x     = wall_x_q;
  assign touched    = touched_q;
  assign busy       = busy_q;

endmodule
